ac_motor_rotation_decoder: RTL and testbench

AC_MOTOR_ROTATION_DECODER -- requirements
Module: ac_motor_rotation_decoder

---
 rtl/ac_motor_rotation_decoder.sv | 192 +++++++++++++++++++
 tb/tb_ac_motor_rotation_decoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_motor_rotation_decoder.sv
// ac_motor_rotation_decoder
// Decodes three asynchronous commutation signals {S1,S2,S3} into a step pulse,
// a signed wrap-around position count, direction flags, a stall flag and a
// sticky fault flag. Optional period measurement is enabled by defining
// AC_MOTOR_PERIOD_MEAS_EN, which adds the PERIOD output.
//
// state | meaning
// ------+--------------------------------------------------------------
// NOREF | no reference code held; next valid code becomes the reference
// TRACK | reference held; adjacent codes step, anything else faults
module ac_motor_rotation_decoder #(
    parameter int CNT_W        = 16,
    parameter int STALL_CYCLES = 1000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             S1_IN,
    input  logic             S2_IN,
    input  logic             S3_IN,
    input  logic             FAULT_CLR,
    output logic             CW_DET,
    output logic             CCW_DET,
    output logic             STEP_PULSE,
    output logic [CNT_W-1:0] STEP_CNT,
    output logic             STALL,
    output logic             FAULT
`ifdef AC_MOTOR_PERIOD_MEAS_EN
    ,
    output logic [23:0]      PERIOD
`endif
);

    localparam int                IDLE_W   = $clog2(STALL_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(STALL_CYCLES);

    typedef enum logic {
        NOREF = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t            state;
    logic [2:0]        s_meta;
    logic [2:0]        s_sync;
    logic [2:0]        ref_code;
    logic [IDLE_W-1:0] idle_cnt;

    logic              code_valid;
    logic              step_ccw;
    logic              step_cw;
    logic              step_valid;
    logic              bad_code;
    logic [IDLE_W-1:0] idle_next;
    logic              stall_next;

    // Successor of a code in the CCW rotation; illegal codes map to 000.
    function automatic logic [2:0] next_ccw(input logic [2:0] c);
        case (c)
            3'b100:  next_ccw = 3'b110;
            3'b110:  next_ccw = 3'b010;
            3'b010:  next_ccw = 3'b011;
            3'b011:  next_ccw = 3'b001;
            3'b001:  next_ccw = 3'b101;
            3'b101:  next_ccw = 3'b100;
            default: next_ccw = 3'b000;
        endcase
    endfunction

    // Successor of a code in the CW rotation (reverse of CCW).
    function automatic logic [2:0] next_cw(input logic [2:0] c);
        case (c)
            3'b100:  next_cw = 3'b101;
            3'b101:  next_cw = 3'b001;
            3'b001:  next_cw = 3'b011;
            3'b011:  next_cw = 3'b010;
            3'b010:  next_cw = 3'b110;
            3'b110:  next_cw = 3'b100;
            default: next_cw = 3'b000;
        endcase
    endfunction

    // Two-flop synchronizer on all three commutation inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s_meta <= 3'b000;
            s_sync <= 3'b000;
        end else begin
            s_meta <= {S1_IN, S2_IN, S3_IN};
            s_sync <= s_meta;
        end
    end

    // Classify the synchronized code against the held reference.
    always_comb begin
        code_valid = (s_sync != 3'b000) && (s_sync != 3'b111);
        step_ccw   = (state == TRACK) && (s_sync == next_ccw(ref_code));
        step_cw    = (state == TRACK) && (s_sync == next_cw(ref_code));
        step_valid = step_ccw || step_cw;
        // The reference is always legal, so an illegal code can never
        // equal it or its neighbours and falls into this case too.
        bad_code   = (state == TRACK) && (s_sync != ref_code) && !step_valid;
        if (step_valid)
            idle_next = '0;
        else if (idle_cnt == IDLE_MAX)
            idle_next = idle_cnt;
        else
            idle_next = idle_cnt + 1'b1;
        stall_next = (idle_next == IDLE_MAX);
    end

    // Reference-tracking FSM with registered step, count, direction, stall and fault outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= NOREF;
            ref_code   <= 3'b000;
            STEP_CNT   <= '0;
            STEP_PULSE <= 1'b0;
            CW_DET     <= 1'b0;
            CCW_DET    <= 1'b0;
            STALL      <= 1'b0;
            FAULT      <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            STEP_PULSE <= step_valid;
            idle_cnt   <= idle_next;
            STALL      <= stall_next;

            case (state)
                NOREF: begin
                    if (code_valid) begin
                        ref_code <= s_sync;
                        state    <= TRACK;
                    end
                end
                TRACK: begin
                    if (step_ccw) begin
                        ref_code <= s_sync;
                        STEP_CNT <= STEP_CNT + 1'b1;
                    end else if (step_cw) begin
                        ref_code <= s_sync;
                        STEP_CNT <= STEP_CNT - 1'b1;
                    end else if (bad_code) begin
                        state <= NOREF;
                    end
                end
                default: state <= NOREF;
            endcase

            if (stall_next) begin
                CW_DET  <= 1'b0;
                CCW_DET <= 1'b0;
            end else if (step_ccw) begin
                CW_DET  <= 1'b0;
                CCW_DET <= 1'b1;
            end else if (step_cw) begin
                CW_DET  <= 1'b1;
                CCW_DET <= 1'b0;
            end

            // A fresh fault outranks a simultaneous clear request.
            if (bad_code)
                FAULT <= 1'b1;
            else if (FAULT_CLR)
                FAULT <= 1'b0;
        end
    end

`ifdef AC_MOTOR_PERIOD_MEAS_EN
    logic [23:0] since_cnt;
    logic [23:0] since_inc;

    // Saturating count of cycles elapsed, including the current edge.
    always_comb begin
        since_inc = (since_cnt == 24'hFF_FFFF) ? since_cnt : since_cnt + 24'd1;
    end

    // Latch cycles between valid steps; a stall wipes the last measurement.
    always_ff @(posedge CLK) begin
        if (RST) begin
            since_cnt <= '0;
            PERIOD    <= '0;
        end else if (step_valid) begin
            since_cnt <= '0;
            PERIOD    <= since_inc;
        end else begin
            since_cnt <= since_inc;
            if (stall_next)
                PERIOD <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_ac_motor_rotation_decoder.sv
// Bench for ac_motor_rotation_decoder: directed scenarios plus randomized
// commutation traffic, checked every cycle against a position-index model.
module tb_ac_motor_rotation_decoder;

    localparam int CNT_W = 16;
    localparam int STALL = 50;
    localparam logic [2:0] SEQ [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             S1_IN = 1'b0, S2_IN = 1'b0, S3_IN = 1'b0;
    logic             FAULT_CLR = 1'b0;
    logic             CW_DET, CCW_DET, STEP_PULSE, STALL_O, FAULT;
    logic [CNT_W-1:0] STEP_CNT;
`ifdef AC_MOTOR_PERIOD_MEAS_EN
    logic [23:0]      PERIOD;
`endif

    ac_motor_rotation_decoder #(.CNT_W(CNT_W), .STALL_CYCLES(STALL)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .S1_IN      (S1_IN),
        .S2_IN      (S2_IN),
        .S3_IN      (S3_IN),
        .FAULT_CLR  (FAULT_CLR),
        .CW_DET     (CW_DET),
        .CCW_DET    (CCW_DET),
        .STEP_PULSE (STEP_PULSE),
        .STEP_CNT   (STEP_CNT),
        .STALL      (STALL_O),
        .FAULT      (FAULT)
`ifdef AC_MOTOR_PERIOD_MEAS_EN
        ,
        .PERIOD     (PERIOD)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int seq_idx(input logic [2:0] c);
        for (int i = 0; i < 6; i++)
            if (SEQ[i] == c) return i;
        return -1;
    endfunction

    // Reference model: rotor position as an index into the 6-code ring.
    logic [2:0]       m_d1 = 0, m_d2 = 0;
    bit               m_have = 0;
    int               m_ref = 0;
    logic [CNT_W-1:0] m_cnt = 0;
    bit               m_cw = 0, m_ccw = 0, m_pulse = 0, m_stall = 0, m_fault = 0;
    int               m_idle = 0;
    int               m_since = 0;
    logic [23:0]      m_period = 0;

    always @(posedge CLK) begin
        logic [2:0] code;
        int idx, d;
        bit stp, bad;
        if (RST) begin
            m_d1 = 0; m_d2 = 0; m_have = 0; m_ref = 0; m_cnt = 0;
            m_cw = 0; m_ccw = 0; m_pulse = 0; m_stall = 0; m_fault = 0;
            m_idle = 0; m_since = 0; m_period = 0;
        end else begin
            code = m_d2;
            m_d2 = m_d1;
            m_d1 = {S1_IN, S2_IN, S3_IN};
            stp = 0; bad = 0;
            idx = seq_idx(code);
            if (!m_have) begin
                if (idx >= 0) begin m_have = 1; m_ref = idx; end
            end else if (idx != m_ref) begin
                d = (idx < 0) ? -1 : (idx - m_ref + 6) % 6;
                if (d == 1) begin
                    m_cnt = m_cnt + 1; m_ccw = 1; m_cw = 0; stp = 1; m_ref = idx;
                end else if (d == 5) begin
                    m_cnt = m_cnt - 1; m_cw = 1; m_ccw = 0; stp = 1; m_ref = idx;
                end else begin
                    bad = 1; m_have = 0;
                end
            end
            m_pulse = stp;
            m_idle  = stp ? 0 : ((m_idle < STALL) ? m_idle + 1 : STALL);
            m_stall = (m_idle == STALL);
            if (m_stall) begin m_cw = 0; m_ccw = 0; end
            m_fault = bad ? 1'b1 : (FAULT_CLR ? 1'b0 : m_fault);
            m_since = (m_since < 24'hFF_FFFF) ? m_since + 1 : 24'hFF_FFFF;
            if (stp) begin m_period = 24'(m_since); m_since = 0; end
            else if (m_stall) m_period = 0;
        end
    end

    bit chk_en = 0;

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("step_pulse", STEP_PULSE, m_pulse);
            chk("step_cnt", STEP_CNT, m_cnt);
            chk("cw_det", CW_DET, m_cw);
            chk("ccw_det", CCW_DET, m_ccw);
            chk("stall", STALL_O, m_stall);
            chk("fault", FAULT, m_fault);
            chk("dir_excl", CW_DET & CCW_DET, 0);
`ifdef AC_MOTOR_PERIOD_MEAS_EN
            chk("period", PERIOD, m_period);
`endif
        end
    end

    task automatic set_code(input logic [2:0] c);
        {S1_IN, S2_IN, S3_IN} = c;
    endtask

    task automatic put(input logic [2:0] c, input int hold);
        @(posedge CLK); #1;
        set_code(c);
        repeat (hold) @(posedge CLK);
    endtask

    // Apply a code and report how many edges later STEP_PULSE shows (99 = none).
    task automatic apply_and_wait(input logic [2:0] c, output int lat);
        @(posedge CLK); #1;
        set_code(c);
        lat = 99;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            if (STEP_PULSE) begin lat = i - 1; break; end
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        set_code(3'b000);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    initial begin
        int lat;
        int drv;
        int r;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst_cnt", STEP_CNT, 0);
        chk("rst_dirs", {CW_DET, CCW_DET, STEP_PULSE, STALL_O, FAULT}, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        chk_en = 1;

        // CCW rotation: first code is reference only, then 3 steps.
        apply_and_wait(3'b100, lat);
        chk("ref_no_step", lat, 99);
        apply_and_wait(3'b110, lat);
        chk("lat_110", lat, 3);
        apply_and_wait(3'b010, lat);
        chk("lat_010", lat, 3);
        apply_and_wait(3'b011, lat);
        chk("lat_011", lat, 3);
        chk("ccw_cnt3", STEP_CNT, 3);
        chk("ccw_det3", CCW_DET, 1);

        // CW rotation wraps below zero.
        do_reset();
        put(3'b100, 4);
        apply_and_wait(3'b101, lat);
        apply_and_wait(3'b001, lat);
        chk("cw_wrap", STEP_CNT, 16'hFFFE);
        chk("cw_dirs", {CW_DET, CCW_DET}, 2'b10);

        // Illegal code faults; recovery needs a fresh reference.
        do_reset();
        put(3'b100, 4);
        apply_and_wait(3'b111, lat);
        chk("illegal_nostep", lat, 99);
        chk("illegal_fault", FAULT, 1);
        apply_and_wait(3'b100, lat);
        chk("reacq_nostep", lat, 99);
        apply_and_wait(3'b110, lat);
        chk("resume_step", lat, 3);
        chk("resume_cnt", STEP_CNT, 1);
        chk("fault_sticky", FAULT, 1);
        @(posedge CLK); #1 FAULT_CLR = 1'b1;
        @(posedge CLK); #1 FAULT_CLR = 1'b0;
        @(negedge CLK);
        chk("fault_clr", FAULT, 0);
        // Non-adjacent jump coinciding with FAULT_CLR: fault wins.
        put(3'b110, 4);
        @(posedge CLK); #1 set_code(3'b011);
        @(posedge CLK);
        @(posedge CLK); #1 FAULT_CLR = 1'b1;
        @(posedge CLK); #1 FAULT_CLR = 1'b0;
        @(negedge CLK);
        chk("fault_wins", FAULT, 1);

        // Stall timing and recovery.
        do_reset();
        put(3'b100, 4);
        apply_and_wait(3'b110, lat);
        chk("pre_stall_step", lat, 3);
        lat = 999;
        for (int k = 1; k <= 80; k++) begin
            @(negedge CLK);
            if (STALL_O) begin lat = k; break; end
        end
        chk("stall_delay", lat, STALL);
        chk("stall_dirs", {CW_DET, CCW_DET}, 0);
        apply_and_wait(3'b010, lat);
        chk("unstall_step", lat, 3);
        chk("unstall_flag", STALL_O, 0);
        chk("unstall_ccw", CCW_DET, 1);

`ifdef AC_MOTOR_PERIOD_MEAS_EN
        // Steps 20 cycles apart, then reset mid-rotation.
        do_reset();
        put(3'b100, 4);
        apply_and_wait(3'b110, lat);
        repeat (16) @(posedge CLK);
        apply_and_wait(3'b010, lat);
        chk("period20", PERIOD, 20);
        do_reset();
        @(negedge CLK);
        chk("rst_period", PERIOD, 0);
        chk("rst_outs", {CW_DET, CCW_DET, STEP_PULSE, STALL_O, FAULT}, 0);
        apply_and_wait(3'b011, lat);
        chk("post_rst_ref", lat, 99);
        chk("post_rst_cnt", STEP_CNT, 0);
`endif

        // Randomized traffic.
        do_reset();
        drv = $urandom_range(0, 5);
        put(SEQ[drv], 3);
        for (int it = 0; it < 600; it++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                drv = (drv + 1) % 6;
                put(SEQ[drv], $urandom_range(0, 4));
            end else if (r < 75) begin
                drv = (drv + 5) % 6;
                put(SEQ[drv], $urandom_range(0, 4));
            end else if (r < 85) begin
                repeat ($urandom_range(1, 4)) @(posedge CLK);
            end else if (r < 90) begin
                put(($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000, $urandom_range(0, 3));
            end else if (r < 94) begin
                drv = (drv + $urandom_range(2, 4)) % 6;
                put(SEQ[drv], $urandom_range(0, 3));
            end else if (r < 96) begin
                repeat ($urandom_range(STALL - 5, STALL + 20)) @(posedge CLK);
            end else if (r < 98) begin
                @(posedge CLK); #1 FAULT_CLR = 1'b1;
                @(posedge CLK); #1 FAULT_CLR = 1'b0;
            end else begin
                do_reset();
                put(SEQ[drv], 1);
            end
        end
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
